// File: rtl/demux_channel_deserializer.sv
// Four independent serial-to-parallel channels fed by a 1:4 demux. Each channel
// assembles WIDTH-bit words MSB-first and holds them behind a valid/ack handshake.
module demux_channel_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [1:0]       Select_In,
  input  logic             Data_0_In,
  input  logic             Data_1_In,
  input  logic             Data_2_In,
  input  logic             Data_3_In,
  input  logic [3:0]       Ack_In,
  input  logic             Clear_In,
  output logic [WIDTH-1:0] Word_0_Out,
  output logic [WIDTH-1:0] Word_1_Out,
  output logic [WIDTH-1:0] Word_2_Out,
  output logic [WIDTH-1:0] Word_3_Out,
  output logic [3:0]       Valid_Out,
  output logic [3:0]       Overflow_Out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift [4];
  logic [CW-1:0]    r_count [4];
  logic [WIDTH-1:0] r_word  [4];
  logic [3:0]       r_valid;
  logic [3:0]       r_ovf;

  logic [3:0]       w_data;
  logic [3:0]       w_sample;
  logic [3:0]       w_done;
  logic [WIDTH-1:0] w_next [4];

  assign w_data = {Data_3_In, Data_2_In, Data_1_In, Data_0_In};

  always_comb begin
    w_sample = '0;
    w_done   = '0;
    for (int n = 0; n < 4; n++) begin
      w_sample[n] = Enable_In && (Select_In == 2'(n));
      w_done[n]   = w_sample[n] && (r_count[n] == LAST);
      w_next[n]   = {r_shift[n][WIDTH-2:0], w_data[n]};
    end
  end

  // Handshake: Valid_Out[n] rises the edge after a word completes and holds,
  // with Word_n_Out stable, until an edge sees Ack_In[n]=1. A completion on the
  // acking edge reloads the word and keeps valid high; a completion while valid
  // and unacked overwrites the word and sets the sticky overflow flag.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      for (int n = 0; n < 4; n++) begin
        r_shift[n] <= '0;
        r_count[n] <= '0;
        r_word[n]  <= '0;
      end
      r_valid <= '0;
      r_ovf   <= '0;
    end else if (Clear_In) begin
      // Flush in-flight state but keep the last delivered words visible.
      for (int n = 0; n < 4; n++) begin
        r_shift[n] <= '0;
        r_count[n] <= '0;
      end
      r_valid <= '0;
      r_ovf   <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_sample[n]) begin
          r_shift[n] <= w_next[n];
          r_count[n] <= w_done[n] ? '0 : r_count[n] + 1'b1;
        end
        if (w_done[n]) begin
          r_word[n]  <= w_next[n];
          r_valid[n] <= 1'b1;
          if (r_valid[n] && !Ack_In[n]) r_ovf[n] <= 1'b1;
        end else if (Ack_In[n]) begin
          r_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign Word_0_Out   = r_word[0];
  assign Word_1_Out   = r_word[1];
  assign Word_2_Out   = r_word[2];
  assign Word_3_Out   = r_word[3];
  assign Valid_Out    = r_valid;
  assign Overflow_Out = r_ovf;

endmodule
